// File: rtl/pipe_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// pipe_fetch_unit_pkg
// Shared definitions for the fetch stage of the pipelined CPU:
//   - fetch_state_t      : fetch controller states (IDLE, RUN, HALT)
//   - NOP_WORD           : instruction returned for fetches outside imem
//   - DEFAULT_HALT_WORD  : default sentinel instruction that stops fetching
// No ports; import with pipe_fetch_unit_pkg::*.
// -----------------------------------------------------------------------------
package pipe_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_WORD          = 32'h0000_0020;
    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/pipe_fetch_unit_imem.sv
// -----------------------------------------------------------------------------
// imem_ram
// Instruction memory for the fetch stage. One clocked write port used by the
// program loader, one combinational read port whose result the fetch stage
// captures in its own register (so the read is used synchronously).
// The memory has no reset, so a loaded program survives a CPU reset.
// Ports:
//   clk    : clock, writes on rising edge
//   we     : write enable
//   waddr  : write word index
//   wdata  : write data
//   raddr  : read word index
//   rdata  : read data (combinational from raddr)
// -----------------------------------------------------------------------------
module imem_ram #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] mem [DEPTH];

    // Loader write port; no reset so contents persist across CPU resets.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_fetch_unit.sv
// -----------------------------------------------------------------------------
// pipe_fetch_unit
// Instruction fetch stage with a built-in loadable instruction memory.
// In IDLE the program is loaded through the ld_* port; start begins fetching
// at RESET_PC. Each RUN cycle fetches one word into the fetch/decode register
// (fd_*), honouring stall and redirect. Fetching stops permanently (until rst)
// when the HALT_WORD sentinel is presented or the RUN-cycle budget runs out.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   ld_en/addr/data : imem load port (effective in IDLE only)
//   start           : IDLE -> RUN
//   stall           : hold pc and fd_* registers
//   redirect_valid  : taken branch/jump, overrides stall, flushes fd_valid
//   redirect_pc     : byte target of redirect (low two bits ignored)
//   fd_valid        : fd_pc/fd_instr hold a real fetched instruction
//   fd_pc, fd_instr : byte PC and fetched instruction
//   halted          : block is in HALT
//   cycle_count     : RUN cycles elapsed (saturating)
// -----------------------------------------------------------------------------
module pipe_fetch_unit
    import pipe_fetch_unit_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter int              IMEM_DEPTH = 256,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     MAX_CYCLES = 20560,
    parameter logic [XLEN-1:0] HALT_WORD  = XLEN'(DEFAULT_HALT_WORD),
    localparam int             AW         = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld_en,
    input  logic [AW-1:0]   ld_addr,
    input  logic [XLEN-1:0] ld_data,
    input  logic            start,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fd_valid,
    output logic [XLEN-1:0] fd_pc,
    output logic [XLEN-1:0] fd_instr,
    output logic            halted,
    output logic [31:0]     cycle_count
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imem_rdata;
    logic [XLEN-1:0] fetch_word;
    logic            in_range;
    logic            sentinel_hit;
    logic            budget_hit;

    imem_ram #(
        .XLEN  (XLEN),
        .DEPTH (IMEM_DEPTH),
        .AW    (AW)
    ) u_imem (
        .clk   (clk),
        .we    (ld_en && (state == ST_IDLE)),
        .waddr (ld_addr),
        .wdata (ld_data),
        .raddr (pc[AW+1:2]),
        .rdata (imem_rdata)
    );

    // Word indices past the end of imem read as a NOP rather than aliasing.
    assign in_range     = (pc >> 2) < XLEN'(IMEM_DEPTH);
    assign fetch_word   = in_range ? imem_rdata : XLEN'(NOP_WORD);

    // The sentinel halts the cycle after it is presented in the fd register.
    assign sentinel_hit = fd_valid && (fd_instr == HALT_WORD);
    assign budget_hit   = (cycle_count == 32'(MAX_CYCLES - 1));

    // Fetch controller and fetch/decode register. Budget exhaustion freezes
    // cycle_count at MAX_CYCLES-1; a sentinel halt still counts its final
    // RUN cycle. Redirect wins over stall and flushes the fd register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            fd_valid    <= 1'b0;
            fd_pc       <= '0;
            fd_instr    <= '0;
            halted      <= 1'b0;
            cycle_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    fd_valid    <= 1'b0;
                    halted      <= 1'b0;
                    cycle_count <= '0;
                    if (start) begin
                        state <= ST_RUN;
                        pc    <= RESET_PC;
                    end
                end

                ST_RUN: begin
                    if (budget_hit) begin
                        state    <= ST_HALT;
                        halted   <= 1'b1;
                        fd_valid <= 1'b0;
                    end else begin
                        if (cycle_count != 32'hFFFF_FFFF) begin
                            cycle_count <= cycle_count + 32'd1;
                        end
                        if (sentinel_hit) begin
                            state    <= ST_HALT;
                            halted   <= 1'b1;
                            fd_valid <= 1'b0;
                        end else if (redirect_valid) begin
                            pc       <= {redirect_pc[XLEN-1:2], 2'b00};
                            fd_valid <= 1'b0;
                        end else if (!stall) begin
                            fd_instr <= fetch_word;
                            fd_pc    <= pc;
                            fd_valid <= 1'b1;
                            pc       <= pc + XLEN'(4);
                        end
                    end
                end

                ST_HALT: begin
                    fd_valid <= 1'b0;
                    halted   <= 1'b1;
                end

                default: begin
                    state    <= ST_IDLE;
                    fd_valid <= 1'b0;
                    halted   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pipe_fetch_unit
// Directed bench for pipe_fetch_unit. dut drives the default configuration
// through load, fetch, stall, redirect, sentinel halt and asynchronous reset.
// dut2 uses a 10-cycle budget and a start PC outside its 16-word imem, so it
// fetches only NOPs and halts on budget.
// -----------------------------------------------------------------------------
module tb_pipe_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [31:0] ld_data;
    logic        start;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fd_valid;
    logic [31:0] fd_pc;
    logic [31:0] fd_instr;
    logic        halted;
    logic [31:0] cycle_count;

    logic        rst2;
    logic        start2;
    logic        zero2    = 1'b0;
    logic [3:0]  ld_addr2 = 4'd0;
    logic [31:0] zero32   = 32'd0;
    logic        fd_valid2;
    logic [31:0] fd_pc2;
    logic [31:0] fd_instr2;
    logic        halted2;
    logic [31:0] cycle_count2;

    int checks = 0;
    int errors = 0;

    // Program words loaded before start; word 0 is written together with start.
    logic [7:0]  load_addrs [7] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd8, 8'd9};
    logic [31:0] load_words [7] = '{32'h22, 32'h33, 32'h44, 32'h55,
                                    32'hFFFF_FFFF, 32'h88, 32'h99};
    logic [31:0] first_words [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

    always #5 clk = ~clk;

    pipe_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .ld_en          (ld_en),
        .ld_addr        (ld_addr),
        .ld_data        (ld_data),
        .start          (start),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fd_valid       (fd_valid),
        .fd_pc          (fd_pc),
        .fd_instr       (fd_instr),
        .halted         (halted),
        .cycle_count    (cycle_count)
    );

    pipe_fetch_unit #(
        .XLEN       (32),
        .IMEM_DEPTH (16),
        .RESET_PC   (32'h0000_0100),
        .MAX_CYCLES (10)
    ) dut2 (
        .clk            (clk),
        .rst            (rst2),
        .ld_en          (zero2),
        .ld_addr        (ld_addr2),
        .ld_data        (zero32),
        .start          (start2),
        .stall          (zero2),
        .redirect_valid (zero2),
        .redirect_pc    (zero32),
        .fd_valid       (fd_valid2),
        .fd_pc          (fd_pc2),
        .fd_instr       (fd_instr2),
        .halted         (halted2),
        .cycle_count    (cycle_count2)
    );

    // Drive every dut input in one step.
    task automatic applyStimulus(input logic l_en, input logic [7:0] l_addr,
                                 input logic [31:0] l_data, input logic s,
                                 input logic st, input logic rv,
                                 input logic [31:0] rp);
        ld_en          = l_en;
        ld_addr        = l_addr;
        ld_data        = l_data;
        start          = s;
        stall          = st;
        redirect_valid = rv;
        redirect_pc    = rp;
    endtask

    // Compare one observed value with its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        rst    = 1'b1;
        rst2   = 1'b1;
        start2 = 1'b0;
        idleInputs();
        #2;
        checkOutput("rst_valid", 32'(fd_valid), 32'd0);
        checkOutput("rst_pc", fd_pc, 32'd0);
        checkOutput("rst_instr", fd_instr, 32'd0);
        checkOutput("rst_halted", 32'(halted), 32'd0);
        checkOutput("rst_count", cycle_count, 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        rst2 = 1'b0;

        // Load program in IDLE, then word 0 in the same cycle as start.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, load_addrs[i], load_words[i], 1'b0, 1'b0, 1'b0, 32'd0);
            tick();
        end
        applyStimulus(1'b1, 8'd0, 32'h11, 1'b1, 1'b0, 1'b0, 32'd0);
        tick();
        checkOutput("start_valid", 32'(fd_valid), 32'd0);
        checkOutput("start_count", cycle_count, 32'd0);
        idleInputs();

        // Straight-line fetch of words 0..3.
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("seq_instr", fd_instr, first_words[i]);
            checkOutput("seq_pc", fd_pc, 32'(i * 4));
            checkOutput("seq_valid", 32'(fd_valid), 32'd1);
        end

        // Asynchronous reset in the middle of a cycle.
        #3 rst = 1'b1;
        #1;
        checkOutput("arst_valid", 32'(fd_valid), 32'd0);
        checkOutput("arst_pc", fd_pc, 32'd0);
        checkOutput("arst_instr", fd_instr, 32'd0);
        checkOutput("arst_count", cycle_count, 32'd0);
        #2 rst = 1'b0;

        // Restart with retained program.
        applyStimulus(1'b0, 8'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0);
        tick();
        idleInputs();
        tick();
        checkOutput("re_instr0", fd_instr, 32'h11);
        checkOutput("re_pc0", fd_pc, 32'd0);
        tick();
        checkOutput("re_instr1", fd_instr, 32'h22);
        checkOutput("re_pc1", fd_pc, 32'd4);
        checkOutput("re_count", cycle_count, 32'd2);

        // Stall three cycles at fd_pc = 4.
        applyStimulus(1'b0, 8'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("stall_pc", fd_pc, 32'd4);
            checkOutput("stall_instr", fd_instr, 32'h22);
            checkOutput("stall_valid", 32'(fd_valid), 32'd1);
        end
        checkOutput("stall_count", cycle_count, 32'd5);
        idleInputs();
        tick();
        checkOutput("unstall_pc", fd_pc, 32'd8);
        checkOutput("unstall_instr", fd_instr, 32'h33);

        // Redirect with stall also high; target 0x23 aligns to 0x20.
        applyStimulus(1'b0, 8'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h23);
        tick();
        checkOutput("redir_flush", 32'(fd_valid), 32'd0);
        idleInputs();
        tick();
        checkOutput("redir_pc", fd_pc, 32'h20);
        checkOutput("redir_instr", fd_instr, 32'h88);
        checkOutput("redir_valid", 32'(fd_valid), 32'd1);
        tick();
        checkOutput("redir_pc2", fd_pc, 32'h24);
        checkOutput("redir_instr2", fd_instr, 32'h99);

        // Redirect to word 4, then run into the sentinel at word 5.
        applyStimulus(1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h10);
        tick();
        checkOutput("jmp_flush", 32'(fd_valid), 32'd0);
        idleInputs();
        tick();
        checkOutput("jmp_pc", fd_pc, 32'h10);
        checkOutput("jmp_instr", fd_instr, 32'h55);
        tick();
        checkOutput("sent_instr", fd_instr, 32'hFFFF_FFFF);
        checkOutput("sent_pc", fd_pc, 32'd20);
        checkOutput("sent_valid", 32'(fd_valid), 32'd1);
        checkOutput("sent_halted", 32'(halted), 32'd0);
        tick();
        checkOutput("halt_halted", 32'(halted), 32'd1);
        checkOutput("halt_valid", 32'(fd_valid), 32'd0);
        checkOutput("halt_count", cycle_count, 32'd13);

        // Loads in HALT must be ignored; state stays frozen.
        applyStimulus(1'b1, 8'd0, 32'h77, 1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        idleInputs();
        tick();
        checkOutput("frz_halted", 32'(halted), 32'd1);
        checkOutput("frz_count", cycle_count, 32'd13);
        checkOutput("frz_valid", 32'(fd_valid), 32'd0);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        checkOutput("rst2_halted", 32'(halted), 32'd0);
        applyStimulus(1'b0, 8'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0);
        tick();
        idleInputs();
        tick();
        checkOutput("noload_instr", fd_instr, 32'h11);

        // Budget halt on dut2: NOPs from out-of-range addresses.
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) begin
                checkOutput("nop_instr", fd_instr2, 32'h20);
                checkOutput("nop_pc", fd_pc2, 32'h100);
                checkOutput("nop_valid", 32'(fd_valid2), 32'd1);
            end
            if (k == 9) begin
                checkOutput("bud_pre_count", cycle_count2, 32'd9);
                checkOutput("bud_pre_halted", 32'(halted2), 32'd0);
                checkOutput("bud_pre_pc", fd_pc2, 32'h120);
            end
            if (k == 10) begin
                checkOutput("bud_halted", 32'(halted2), 32'd1);
                checkOutput("bud_count", cycle_count2, 32'd9);
                checkOutput("bud_valid", 32'(fd_valid2), 32'd0);
            end
        end
        tick();
        tick();
        checkOutput("bud_frz_count", cycle_count2, 32'd9);
        checkOutput("bud_frz_halted", 32'(halted2), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
